// File: rtl/bound_flasher_pkg.sv
// ----------------------------------------------------------------------------
// bound_flasher_pkg
//
// Shared definitions for the parametrised bound flasher:
//   - phase_t : sequence phase (IDLE, P1..P6) with its 3-bit status encoding
//   - PH_*    : the same encoding as plain constants for the board top-level
//               and the debug LED mux, which see phase as a bare 3-bit bus
//   - phase_is_up()  : bar direction of a phase
//   - phase_next()   : phase that follows a completed phase
// ----------------------------------------------------------------------------
package bound_flasher_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        P4   = 3'd4,
        P5   = 3'd5,
        P6   = 3'd6
    } phase_t;

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_P1   = 3'd1;
    localparam logic [2:0] PH_P2   = 3'd2;
    localparam logic [2:0] PH_P3   = 3'd3;
    localparam logic [2:0] PH_P4   = 3'd4;
    localparam logic [2:0] PH_P5   = 3'd5;
    localparam logic [2:0] PH_P6   = 3'd6;

    // Odd phases fill the bar, even phases drain it.
    function automatic logic phase_is_up(phase_t p);
        return (p == P1) || (p == P3) || (p == P5);
    endfunction

    // Successor of a phase that has just reached its end level. P6 either
    // wraps to P1 (auto-repeat) or returns to IDLE.
    function automatic phase_t phase_next(phase_t p, logic rep);
        phase_t n;
        case (p)
            P1:      n = P2;
            P2:      n = P3;
            P3:      n = P4;
            P4:      n = P5;
            P5:      n = P6;
            P6:      n = rep ? P1 : IDLE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage : bound_flasher_pkg

// File: rtl/bf_step_prescaler.sv
// ----------------------------------------------------------------------------
// bf_step_prescaler
//
// Divides the clock into bar-step strobes. The counter runs 0..STEP_DIV-1
// while enabled and is held at 0 while disabled, so the first strobe after
// enabling arrives exactly STEP_DIV clocks later.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   en      in   count enable (sequence busy)
//   step_en out  one-clock strobe on the last count of each step period
// ----------------------------------------------------------------------------
module bf_step_prescaler #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic step_en
);

    if (STEP_DIV < 1) begin : g_bad_div
        $error("bf_step_prescaler: STEP_DIV must be >= 1");
    end

    // A 1-bit counter is kept even for STEP_DIV=1; it simply stays at 0.
    localparam int            CW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] count_q;

    assign step_en = en && (count_q == CNT_LAST);

    // NOTE: state registers are written only with non-blocking assignments so
    // every flop samples the pre-edge values of all the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (!en || (count_q == CNT_LAST)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule : bf_step_prescaler

// File: rtl/bound_flasher_param.sv
// ----------------------------------------------------------------------------
// bound_flasher_param
//
// Drives an N_LED thermometer bar through a six-phase fill/drain sequence:
//   P1 up to B1+1, P2 down to 0, P3 up to B2+1, P4 down to B1,
//   P5 up to N_LED, P6 down to 0, then IDLE (or P1 again with auto_rep).
// A flick on a step edge while P3 sits at B1+1, or P5 sits at B1+1 or B2+1,
// kicks the bar back one level into the preceding down phase.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   flick     in   start request in IDLE, kickback request on kick levels
//   auto_rep  in   1 = restart P1 after P6 instead of going IDLE
//   led       out  bar, led[i] = (i < level)
//   busy      out  high whenever phase != IDLE
//   phase     out  phase encoding (IDLE=0, P1..P6=1..6)
// ----------------------------------------------------------------------------
module bound_flasher_param
    import bound_flasher_pkg::*;
#(
    parameter int N_LED    = 16,
    parameter int B1       = 5,
    parameter int B2       = 10,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    input  logic             auto_rep,
    output logic [N_LED-1:0] led,
    output logic             busy,
    output logic [2:0]       phase
);

    if (!((B1 > 0) && (B1 < B2) && (B2 < N_LED - 1))) begin : g_bad_bounds
        $error("bound_flasher_param: require 0 < B1 < B2 < N_LED-1");
    end

    localparam int LW = $clog2(N_LED + 1);

    // End levels of each phase; the kick points coincide with the P1 and P3
    // end levels.
    localparam logic [LW-1:0] P1_END  = LW'(B1 + 1);
    localparam logic [LW-1:0] P3_END  = LW'(B2 + 1);
    localparam logic [LW-1:0] P4_END  = LW'(B1);
    localparam logic [LW-1:0] P5_END  = LW'(N_LED);
    localparam logic [LW-1:0] KICK_LO = P1_END;
    localparam logic [LW-1:0] KICK_HI = P3_END;

    phase_t        phase_q, phase_d;
    logic [LW-1:0] level_q, level_d;
    logic          step_en;
    logic          kick;
    phase_t        tgt;
    logic [LW-1:0] end_lvl;

    bf_step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (phase_q != IDLE),
        .step_en (step_en)
    );

    // Step-edge next state. Only consulted while busy and step_en is high;
    // the IDLE values it produces are never loaded.
    // NOTE: every variable assigned here gets a default at the top of the
    // block, so no path can leave one unassigned and infer a latch.
    always_comb begin
        kick    = 1'b0;
        tgt     = phase_q;
        level_d = level_q;
        end_lvl = '0;
        phase_d = phase_q;

        if (flick) begin
            if ((phase_q == P3) && (level_q == KICK_LO)) begin
                kick = 1'b1;
            end
            if ((phase_q == P5) && ((level_q == KICK_LO) || (level_q == KICK_HI))) begin
                kick = 1'b1;
            end
        end

        // A kick moves into the preceding down phase and takes its first
        // step there, replacing the normal increment.
        if (kick) begin
            tgt = (phase_q == P3) ? P2 : P4;
        end

        if (kick || !phase_is_up(tgt)) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q + LW'(1);
        end

        case (tgt)
            P1:      end_lvl = P1_END;
            P3:      end_lvl = P3_END;
            P4:      end_lvl = P4_END;
            P5:      end_lvl = P5_END;
            default: end_lvl = '0;
        endcase

        // The phase advances on the same edge the level lands on its end
        // value, including a kick from P5 at B1+1 that lands straight on the
        // P4 end level.
        if (level_d == end_lvl) begin
            phase_d = phase_next(tgt, auto_rep);
        end else begin
            phase_d = tgt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= IDLE;
            level_q <= '0;
        end else if (phase_q == IDLE) begin
            // Start does not wait for a step; the level stays at 0 and the
            // first increment follows one full step period later.
            if (flick) begin
                phase_q <= P1;
            end
        end else if (step_en) begin
            phase_q <= phase_d;
            level_q <= level_d;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_led
        assign led[i] = (level_q > LW'(i));
    end

    assign busy  = (phase_q != IDLE);
    assign phase = phase_q;

endmodule : bound_flasher_param

// File: doc/bound_flasher_param.md
Name: bound_flasher_param

Overview:
Parametrised successor to the fixed 16-LED bound flasher. It drives an N-LED thermometer bar through a six-phase on/off sequence with configurable bounds, step prescaling, kickback on flick, and an auto-repeat mode. It also exposes busy and phase status for the board top-level and the debug LED mux.

Parameters:
N_LED, 16, number of LEDs; level width LW = $clog2(N_LED+1)
B1, 5, first bound (LED index)
B2, 10, second bound (LED index)
STEP_DIV, 1, clocks per bar step (>=1)
Elaboration error unless 0 < B1 < B2 < N_LED-1 and STEP_DIV >= 1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
flick  in  1  start / kickback request, sampled on clk
auto_rep  in  1  1 = restart P1 after P6 instead of returning to IDLE
led  out  N_LED  bar output; led[i] = (i < L)
busy  out  1  1 whenever phase != IDLE
phase  out  3  current phase encoding (IDLE=0, P1..P6=1..6)

Behaviour:
- Internal level L (LW bits, range 0..N_LED); led is decoded combinationally from L; busy and phase are direct state decodes.
- Reset (rst=0, async): phase=IDLE, L=0, prescale count=0, led=0, busy=0, phase=0. Takes effect immediately, including mid-sequence.
- Prescaler: count runs 0..STEP_DIV-1 while phase != IDLE and is held at 0 in IDLE. step_en = (count == STEP_DIV-1). With STEP_DIV=1, step_en is high every busy cycle.
- IDLE: flick=1 at an edge sets phase=P1, L stays 0. The first increment occurs STEP_DIV clocks later.
- All L changes and phase changes other than the start happen only on step_en edges.
- Phases, direction, and end value (phase advances on the same edge where updated L reaches its end value):
  - P1: up, ends at L=B1+1
  - P2: down, ends at L=0
  - P3: up, ends at L=B2+1
  - P4: down, ends at L=B1
  - P5: up, ends at L=N_LED
  - P6: down, ends at L=0, then P1 if auto_rep=1, else IDLE
- auto_rep is sampled on the final P6 edge.
- Kickback: on a step_en edge, kickback fires when flick=1 and the current L (before update) equals a kick point:
  - P3 kick point: L == B1+1 → phase=P2, L=L-1
  - P5 kick points: L == B1+1 or L == B2+1 → phase=P4, L=L-1
  - Kickback replaces the normal increment.
  - If L-1 equals the end value of the target down phase, the normal end rule applies on that edge.
- flick is ignored at all other times: P1, P2, P4, P6, non-kick levels, and non-step edges.
- A flick held high re-kicks at every qualifying step (bounded livelock is intended).
- L never underflows below 0 or exceeds N_LED; the end-value checks guarantee this.

Decomposition:
- bound_flasher_pkg: phase_t enum (IDLE, P1..P6) and the phase encoding constants.
- Sub-module bf_step_prescaler (STEP_DIV parameter; inputs clk, rst, en; output step_en).
- The FSM and level counter stay in the top module.

Test Plan:
- Defaults, STEP_DIV=1: assert rst for 2 cycles, then release; pulse flick for 1 cycle. L sequence: 0→6→0→11→5→16→0. busy is high for exactly 56 cycles, then phase=IDLE and led=0x0000.
- Kick in P3 (defaults): hold flick=1 on the step where L=6 in P3. Next L=5 with phase=P2; sequence continues 5→0, then P3 restarts, and the total extends by 12 steps.
- Kick in P5 at both points: flick=1 at L=6 gives L=5 and P4→P5 (phase P5 resumes after 1 step). flick=1 at L=11 gives P4, descending to L=5.
- Ignored flick: flick=1 throughout P1, P2, P4 and P6. Sequence identical to the first scenario; flick=1 held continuously from P1 start causes repeated kicks only at P3 L=6 and P5 L=6/11.
- STEP_DIV=4, N_LED=8, B1=2, B2=5, auto_rep=1: each L change is 4 clocks apart. After P6 reaches L=0, phase=P1 with no IDLE cycle. Dropping auto_rep before the final P6 edge gives IDLE.
- Async reset: drive rst=0 mid-P5 (L=12) between clock edges. led=0, phase=0 and busy=0 immediately. After release, remains IDLE until flick.
